io_register_bank: RTL and testbench
===================================

Name: io_register_bank

Overview:
- Memory-mapped I/O register bank for the robot-control I/O module, with registered reads, a read-valid handshake and per-pin edge-triggered interrupts.
- Generalises the earlier 3-register read mux: parametrised pin count and register width, read-modify state (W1C status), input synchronisation, and a combined interrupt request line.
- Sits between the bus/processor interface and the physical I/O pins.

Parameters:
- DATA_WIDTH, 64, width of each register and of the bus data path.
- NUM_IO, 8, number of I/O pins (1..DATA_WIDTH). Register bits at and above NUM_IO read 0 and ignore writes.
- ADDR_WIDTH, 3, register address width (8 slots).

Ports:
- clk  input  1  single system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  write strobe, one cycle per write.
- rd_en  input  1  read strobe, one cycle per read.
- addr  input  ADDR_WIDTH  register address for the current rd_en/wr_en.
- wr_data  input  DATA_WIDTH  write data.
- rd_data  output  DATA_WIDTH  registered read data.
- rd_valid  output  1  high exactly one cycle, the cycle after rd_en.
- io_in  input  NUM_IO  asynchronous pin inputs.
- io_out  output  NUM_IO  output pin values (DATA_OUT register).
- io_oe  output  NUM_IO  per-pin output enable (DIR register).
- irq  output  1  OR of (IRQ_STATUS & IRQ_ENABLE).

Behaviour:
- Reset (async, active-high): all registers, synchroniser flops, rd_data, rd_valid = 0. Therefore io_out = 0, io_oe = 0, irq = 0.
- Register map:
  - 0 DATA_IN: RO, synchronised pins; writes ignored.
  - 1 DATA_OUT: RW.
  - 2 DIR: RW, 1 = output.
  - 3 IRQ_STATUS: RW1C.
  - 4 IRQ_ENABLE: RW.
  - 5 IRQ_RISE: RW.
  - 6 IRQ_FALL: RW.
  - 7: reserved; reads 0, writes ignored.
- Read: rd_en at cycle N; rd_data and rd_valid=1 update at the edge ending N. rd_data holds its value until the next read. rd_valid=0 in any cycle without a preceding rd_en.
- Back-to-back reads are allowed, one per cycle, with rd_valid high continuously.
- Write: takes effect at the edge ending the wr_en cycle.
- rd_en and wr_en in the same cycle are both performed. A read of the address being written returns the pre-write value.
- Input path: 2-flop synchroniser (s1, s2) plus history flop s3.
  - rise[i] = s2 & ~s3; fall[i] = ~s2 & s3.
  - A pin change meeting setup before edge E1 appears in DATA_IN after E2 and in IRQ_STATUS after E3.
- IRQ_STATUS bit i sets when (rise[i] & IRQ_RISE[i]) | (fall[i] & IRQ_FALL[i]). It is sticky until cleared.
- Clear: write 1 to bit i at addr 3; a written 0 has no effect.
- Simultaneous set and clear on the same bit in the same cycle: set wins, and the bit stays 1.
- Status bits set regardless of IRQ_ENABLE. IRQ_ENABLE only masks irq.
- irq is combinational from registered state. It follows the status/enable registers with no added latency and deasserts in the cycle after the clearing write.
- A read of IRQ_STATUS in the same cycle a bit sets returns the old value; the new bit is visible on the next read.
- Pins held high through reset: s3 resets to 0, so a rise is detected after reset. IRQ_RISE resets to 0, so no status bit is set.
- Reset mid-read: rd_valid and rd_data go to 0 immediately, and a pending read is discarded.

Test Plan:
- Reset with io_in=8'hFF → io_out=0, io_oe=0, irq=0, rd_valid=0. Read addr 0 three cycles after reset release → rd_data=64'hFF, rd_valid high for exactly 1 cycle.
- Write DATA_OUT=64'hFFFF_FFFF_0000_01A5 and DIR=64'h0F (NUM_IO=8) → io_out=8'hA5, io_oe=8'h0F. Read addr 1 → 64'hA5 (upper bits masked).
- IRQ_RISE=1, IRQ_ENABLE=1; drive io_in[0] 0→1 → IRQ_STATUS[0]=1 after 3 edges, irq=1. Write 1 to addr 3 → irq=0 next cycle.
- IRQ_FALL[3]=1, IRQ_ENABLE=0; falling edge on pin 3 → status bit 3 set, irq stays 0. Then set IRQ_ENABLE[3]=1 → irq=1.
- W1C write of bit 0 in the same cycle a new rising edge on pin 0 is detected → bit 0 remains 1.
- Back-to-back reads of addr 4, 7, 2 → rd_valid high 3 consecutive cycles, data = enable value, 0, DIR value. Same-cycle read+write of addr 4 returns the old value.

Source files
------------

// File: rtl/io_register_bank.sv
// Memory-mapped I/O register bank: registered reads with a one-cycle
// read-valid, direction/output control and per-pin edge interrupts.
//
// Ports:
//   clk, reset                 clock, async active-high reset
//   wr_en, rd_en, addr         bus strobes and register address
//   wr_data / rd_data          bus write data / registered read data
//   rd_valid                   high the cycle after rd_en
//   io_in                      asynchronous pin inputs
//   io_out, io_oe              DATA_OUT and DIR registers
//   irq                        OR of IRQ_STATUS & IRQ_ENABLE
module io_register_bank #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_IO     = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic [NUM_IO-1:0]     io_in,
    output logic [NUM_IO-1:0]     io_out,
    output logic [NUM_IO-1:0]     io_oe,
    output logic                  irq
);

    localparam logic [ADDR_WIDTH-1:0] A_DIN  = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_DOUT = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_DIR  = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A_STS  = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] A_EN   = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] A_RISE = ADDR_WIDTH'(5);
    localparam logic [ADDR_WIDTH-1:0] A_FALL = ADDR_WIDTH'(6);

    logic [NUM_IO-1:0] s1_q, s2_q, s3_q;
    logic [NUM_IO-1:0] dout_q, dout_d;
    logic [NUM_IO-1:0] dir_q, dir_d;
    logic [NUM_IO-1:0] sts_q, sts_d;
    logic [NUM_IO-1:0] en_q, en_d;
    logic [NUM_IO-1:0] rise_en_q, rise_en_d;
    logic [NUM_IO-1:0] fall_en_q, fall_en_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q;

    logic [NUM_IO-1:0] wd;
    logic [NUM_IO-1:0] rise, fall, set, clr;
    logic [NUM_IO-1:0] rd_sel;

    // Register bits at and above NUM_IO do not exist.
    assign wd = wr_data[NUM_IO-1:0];

    generate
        if (NUM_IO < DATA_WIDTH) begin : g_unused
            logic unused_hi;
            assign unused_hi = ^wr_data[DATA_WIDTH-1:NUM_IO];
        end
    endgenerate

    // s3 is history for edge detection on the synchronised value.
    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;
    assign set  = (rise & rise_en_q) | (fall & fall_en_q);

    always_comb begin
        dout_d    = dout_q;
        dir_d     = dir_q;
        en_d      = en_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        clr       = '0;
        if (wr_en) begin
            case (addr)
                A_DOUT:  dout_d    = wd;
                A_DIR:   dir_d     = wd;
                A_STS:   clr       = wd;
                A_EN:    en_d      = wd;
                A_RISE:  rise_en_d = wd;
                A_FALL:  fall_en_d = wd;
                default: ;
            endcase
        end
        // Set is applied after clear so a same-cycle event wins.
        sts_d = (sts_q & ~clr) | set;
    end

    always_comb begin
        rd_sel = '0;
        case (addr)
            A_DIN:   rd_sel = s2_q;
            A_DOUT:  rd_sel = dout_q;
            A_DIR:   rd_sel = dir_q;
            A_STS:   rd_sel = sts_q;
            A_EN:    rd_sel = en_q;
            A_RISE:  rd_sel = rise_en_q;
            A_FALL:  rd_sel = fall_en_q;
            default: rd_sel = '0;
        endcase
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = '0;
            rd_data_d[NUM_IO-1:0] = rd_sel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q       <= '0;
            s2_q       <= '0;
            s3_q       <= '0;
            dout_q     <= '0;
            dir_q      <= '0;
            sts_q      <= '0;
            en_q       <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            s1_q       <= io_in;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            dout_q     <= dout_d;
            dir_q      <= dir_d;
            sts_q      <= sts_d;
            en_q       <= en_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_en;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign io_out   = dout_q;
    assign io_oe    = dir_q;
    assign irq      = |(sts_q & en_q);

endmodule

// File: tb/tb_io_register_bank.sv
// Directed testbench for io_register_bank (DATA_WIDTH=64, NUM_IO=8).
// Inputs change 1 time unit after the rising edge; outputs sampled there.
module tb_io_register_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic        rd_en;
    logic [2:0]  addr;
    logic [63:0] wr_data;
    logic [63:0] rd_data;
    logic        rd_valid;
    logic [7:0]  io_in;
    logic [7:0]  io_out;
    logic [7:0]  io_oe;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    io_register_bank #(
        .DATA_WIDTH(64),
        .NUM_IO(8),
        .ADDR_WIDTH(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .addr(addr),
        .wr_data(wr_data),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .io_in(io_in),
        .io_out(io_out),
        .io_oe(io_oe),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [2:0] a, input logic [63:0] d);
        wr_en = 1'b1;
        addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
        wr_data = '0;
    endtask

    task automatic do_read(input logic [2:0] a, input logic [63:0] exp,
                           input string tag);
        rd_en = 1'b1;
        addr = a;
        tick();
        rd_en = 1'b0;
        chk({tag, "_valid"}, 64'(rd_valid), 64'd1);
        chk(tag, rd_data, exp);
    endtask

    initial begin
        reset = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        addr = '0;
        wr_data = '0;
        io_in = 8'hFF;
        tick();
        tick();
        chk("rst_io_out", 64'(io_out), 64'h0);
        chk("rst_io_oe", 64'(io_oe), 64'h0);
        chk("rst_irq", 64'(irq), 64'h0);
        chk("rst_rd_valid", 64'(rd_valid), 64'h0);
        chk("rst_rd_data", rd_data, 64'h0);

        reset = 1'b0;
        tick();
        tick();
        tick();
        do_read(3'd0, 64'hFF, "din_ff");
        tick();
        chk("rd_valid_drop", 64'(rd_valid), 64'h0);
        chk("rd_data_hold", rd_data, 64'hFF);
        chk("no_irq_after_rst", 64'(irq), 64'h0);
        do_read(3'd3, 64'h0, "sts_after_rst");

        do_write(3'd1, 64'hFFFF_FFFF_0000_01A5);
        do_write(3'd2, 64'h0F);
        chk("io_out_a5", 64'(io_out), 64'hA5);
        chk("io_oe_0f", 64'(io_oe), 64'h0F);
        do_read(3'd1, 64'hA5, "dout_masked");
        do_read(3'd2, 64'h0F, "dir_rd");
        do_write(3'd0, 64'h0);
        do_read(3'd0, 64'hFF, "din_ro");
        do_write(3'd7, '1);
        do_read(3'd7, 64'h0, "rsvd_zero");

        io_in = 8'h00;
        repeat (4) tick();
        do_read(3'd3, 64'h0, "fall_masked");
        do_write(3'd5, 64'h01);
        do_write(3'd4, 64'h01);
        io_in = 8'h01;
        tick();
        chk("rise_e1", 64'(irq), 64'h0);
        tick();
        chk("rise_e2", 64'(irq), 64'h0);
        tick();
        chk("rise_e3", 64'(irq), 64'h1);
        do_read(3'd3, 64'h01, "sts_rise0");
        do_write(3'd3, 64'h01);
        chk("w1c_irq", 64'(irq), 64'h0);
        do_read(3'd3, 64'h0, "sts_cleared");

        do_write(3'd6, 64'h08);
        do_write(3'd4, 64'h00);
        io_in = 8'h09;
        repeat (4) tick();
        do_read(3'd3, 64'h0, "rise3_masked");
        io_in = 8'h01;
        repeat (3) tick();
        chk("fall3_irq_off", 64'(irq), 64'h0);
        do_read(3'd3, 64'h08, "sts_fall3");
        do_write(3'd4, 64'h08);
        chk("fall3_irq_on", 64'(irq), 64'h1);
        do_write(3'd3, 64'h08);
        chk("fall3_cleared", 64'(irq), 64'h0);

        io_in = 8'h00;
        repeat (4) tick();
        io_in = 8'h01;
        tick();
        tick();
        wr_en = 1'b1;
        rd_en = 1'b1;
        addr = 3'd3;
        wr_data = 64'h01;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("sts_same_cyc_old", rd_data, 64'h0);
        do_read(3'd3, 64'h01, "set_beats_clr");

        do_write(3'd4, 64'h5A);
        do_write(3'd2, 64'h3C);
        rd_en = 1'b1;
        addr = 3'd4;
        tick();
        chk("b2b_v0", 64'(rd_valid), 64'h1);
        chk("b2b_d0", rd_data, 64'h5A);
        addr = 3'd7;
        tick();
        chk("b2b_v1", 64'(rd_valid), 64'h1);
        chk("b2b_d1", rd_data, 64'h0);
        addr = 3'd2;
        tick();
        rd_en = 1'b0;
        chk("b2b_v2", 64'(rd_valid), 64'h1);
        chk("b2b_d2", rd_data, 64'h3C);
        tick();
        chk("b2b_end", 64'(rd_valid), 64'h0);

        wr_en = 1'b1;
        rd_en = 1'b1;
        addr = 3'd4;
        wr_data = 64'hC3;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("rw_old", rd_data, 64'h5A);
        do_read(3'd4, 64'hC3, "rw_new");

        rd_en = 1'b1;
        addr = 3'd2;
        #2;
        reset = 1'b1;
        #1;
        chk("midrd_valid", 64'(rd_valid), 64'h0);
        chk("midrd_data", rd_data, 64'h0);
        chk("midrd_oe", 64'(io_oe), 64'h0);
        tick();
        rd_en = 1'b0;
        chk("midrd_discard", 64'(rd_valid), 64'h0);
        reset = 1'b0;
        tick();
        chk("post_rst_valid", 64'(rd_valid), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
